// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microwave_pkg
// Description : Shared types and BCD helpers for the microwave cook timer.
// Revision    : 1.0 - initial release
// ============================================================================
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // MM:SS is well formed only when every digit is decimal and seconds < 60.
    function automatic logic bcd_valid(
        input logic [3:0] mt,
        input logic [3:0] mo,
        input logic [3:0] st,
        input logic [3:0] so
    );
        return (mt <= DIGIT_MAX) && (mo <= DIGIT_MAX) &&
               (st <= SEC_TENS_MAX) && (so <= DIGIT_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_digit
// Description : One BCD digit of a down-counter; wraps to WRAP and borrows.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit #(
    parameter logic [3:0] WRAP = 4'd9
) (
    input  logic       dec_en,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       borrow
);

    assign q      = (d == 4'd0) ? WRAP : d - 4'd1;
    assign borrow = (d == 4'd0) & dec_en;

endmodule
`default_nettype wire

// File: rtl/microwave_countdown.sv
`default_nettype none
// ============================================================================
// Module      : microwave_countdown
// Description : BCD MM:SS cook timer with run/pause FSM and timed done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module microwave_countdown
    import microwave_pkg::*;
#(
    parameter int DONE_CYCLES = 100
) (
    input  logic       clk_100Hz,
    input  logic       reset,
    input  logic       Hz1,
    input  logic       load,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic       door_open,
    output logic [3:0] disp_mt,
    output logic [3:0] disp_mo,
    output logic [3:0] disp_st,
    output logic [3:0] disp_so,
    output logic       running,
    output logic       magnetron_on,
    output logic       done
);

    localparam logic [7:0] c_done_load = 8'(DONE_CYCLES - 1);

    state_t     r_state, w_state_next;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic [3:0] w_mt_next, w_mo_next, w_st_next, w_so_next;
    logic [7:0] r_done_cnt, w_done_cnt_next;
    logic       r_hz1_q, r_running, r_magnetron, r_done, w_done_next;
    logic       w_tick, w_dec, w_time_zero, w_time_one, w_load_ok;
    logic [3:0] w_q_mt, w_q_mo, w_q_st, w_q_so;
    logic       w_b_mt, w_b_mo, w_b_st, w_b_so;

    assign w_tick      = Hz1 & ~r_hz1_q;
    assign w_time_zero = ({r_mt, r_mo, r_st, r_so} == 16'h0000);
    assign w_time_one  = ({r_mt, r_mo, r_st, r_so} == 16'h0001);
    assign w_load_ok   = bcd_valid(min_tens, min_ones, sec_tens, sec_ones);
    assign w_dec       = w_tick && (r_state == RUNNING) && !cancel && !door_open && !pause;

    bcd_down_digit #(.WRAP(4'd9)) u_so (.dec_en(w_dec),  .d(r_so), .q(w_q_so), .borrow(w_b_so));
    bcd_down_digit #(.WRAP(4'd5)) u_st (.dec_en(w_b_so), .d(r_st), .q(w_q_st), .borrow(w_b_st));
    bcd_down_digit #(.WRAP(4'd9)) u_mo (.dec_en(w_b_st), .d(r_mo), .q(w_q_mo), .borrow(w_b_mo));
    bcd_down_digit #(.WRAP(4'd9)) u_mt (.dec_en(w_b_mo), .d(r_mt), .q(w_q_mt), .borrow(w_b_mt));

    always_comb begin
        w_state_next    = r_state;
        w_mt_next       = r_mt;
        w_mo_next       = r_mo;
        w_st_next       = r_st;
        w_so_next       = r_so;
        w_done_cnt_next = r_done_cnt;
        w_done_next     = r_done;

        if (cancel) begin
            w_state_next    = IDLE;
            {w_mt_next, w_mo_next, w_st_next, w_so_next} = 16'h0000;
            w_done_cnt_next = 8'd0;
            w_done_next     = 1'b0;
        end else begin
            case (r_state)
                RUNNING: begin
                    if (door_open || pause) begin
                        w_state_next = PAUSED;
                    end else if (w_dec && !w_b_mt) begin
                        // A borrow out of the minutes-tens digit would mean 00:00 underflow.
                        w_so_next = w_q_so;
                        if (w_b_so) w_st_next = w_q_st;
                        if (w_b_st) w_mo_next = w_q_mo;
                        if (w_b_mo) w_mt_next = w_q_mt;
                        if (w_time_one) begin
                            w_state_next    = DONE;
                            w_done_next     = 1'b1;
                            w_done_cnt_next = c_done_load;
                        end
                    end
                end
                IDLE, PAUSED: begin
                    if (!pause) begin
                        if (start) begin
                            if (!door_open && !w_time_zero) w_state_next = RUNNING;
                        end else if (load && w_load_ok) begin
                            {w_mt_next, w_mo_next, w_st_next, w_so_next} =
                                {min_tens, min_ones, sec_tens, sec_ones};
                        end
                    end
                end
                DONE: begin
                    if (load && w_load_ok) begin
                        w_state_next    = IDLE;
                        w_done_next     = 1'b0;
                        w_done_cnt_next = 8'd0;
                        {w_mt_next, w_mo_next, w_st_next, w_so_next} =
                            {min_tens, min_ones, sec_tens, sec_ones};
                    end else if (r_done_cnt == 8'd0) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b0;
                    end else begin
                        w_done_cnt_next = r_done_cnt - 8'd1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100Hz) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mt        <= 4'd0;
            r_mo        <= 4'd0;
            r_st        <= 4'd0;
            r_so        <= 4'd0;
            r_done_cnt  <= 8'd0;
            r_hz1_q     <= 1'b0;
            r_running   <= 1'b0;
            r_magnetron <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mt        <= w_mt_next;
            r_mo        <= w_mo_next;
            r_st        <= w_st_next;
            r_so        <= w_so_next;
            r_done_cnt  <= w_done_cnt_next;
            r_hz1_q     <= Hz1;
            r_running   <= (w_state_next == RUNNING);
            r_magnetron <= (w_state_next == RUNNING) && !door_open;
            r_done      <= w_done_next;
        end
    end

    assign disp_mt      = r_mt;
    assign disp_mo      = r_mo;
    assign disp_st      = r_st;
    assign disp_so      = r_so;
    assign running      = r_running;
    assign magnetron_on = r_magnetron;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: doc/microwave_countdown.md
# microwave_countdown

Cook-time countdown for the microwave controller, driven from the 100 Hz system clock and consuming the 1 Hz square wave produced by the frequency-divider stage. Holds a BCD MM:SS cook time (max 99:59), decrements it once per second while cooking, gates the magnetron, and raises a timed completion pulse for the buzzer. Sits between the front-panel keypad/door logic and the display/power drivers.

## Interface
- DONE_CYCLES, 100: clk_100Hz cycles that `done` stays high after reaching 00:00 (1 s at 100 Hz); legal range 1..255.
- clk_100Hz  in  1  system clock, 100 Hz; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- Hz1  in  1  1 Hz square wave, synchronous to clk_100Hz; each rising edge is one elapsed second.
- load  in  1  one-cycle strobe; capture the four BCD inputs below.
- min_tens, min_ones, sec_tens, sec_ones  in  4 each  BCD cook time to load.
- start  in  1  one-cycle strobe; begin or resume cooking.
- pause  in  1  one-cycle strobe; suspend cooking.
- cancel  in  1  one-cycle strobe; abort and clear.
- door_open  in  1  level; high = door open.
- disp_mt, disp_mo, disp_st, disp_so  out  4 each  current remaining time, BCD.
- running  out  1  high in RUNNING.
- magnetron_on  out  1  running & ~door_open, registered.
- done  out  1  high for DONE_CYCLES cycles on completion.

## Operation
- States: IDLE, RUNNING, PAUSED, DONE. Reset: IDLE, all digits 0, running/magnetron_on/done 0, edge register 0, done counter 0.
- Per-cycle priority: reset > cancel > door_open > pause > start > load.
- cancel (any state): digits to 00:00, go IDLE, done cleared.
- load: accepted in IDLE, PAUSED, DONE; ignored in RUNNING. Rejected entirely (no digit changes) if any digit > 9 or sec_tens > 5. Accepted in DONE: go IDLE, done cleared.
- start: IDLE/PAUSED -> RUNNING only if door_open = 0 and time != 00:00; otherwise ignored. Ignored in RUNNING/DONE.
- pause or door_open = 1 in RUNNING -> PAUSED; digits held.
- Tick: `tick = Hz1 & ~hz1_q`, where hz1_q is Hz1 registered every cycle in all states. Only ticks in RUNNING decrement.
- Decrement, MM:SS BCD with borrow chain: sec_ones 0 -> 9 and borrow; sec_tens 0 -> 5 and borrow; min_ones 0 -> 9 and borrow; min_tens decrements on borrow. Never underflows past 00:00.
- Tick at 00:01 -> digits 00:00, go DONE, done = 1, load done counter with DONE_CYCLES-1.
- DONE: counter decrements each cycle; done drops and state returns to IDLE on the cycle after the counter reaches 0.
- Tick coinciding with pause, door_open, or cancel: higher-priority event wins, no decrement.
- Tick on the same cycle as a start that enters RUNNING: no decrement. The first decrement is on the next tick, so the first second may be partial; this is accepted.

## Timing
- All outputs registered. Digits update one cycle after the clock edge on which a tick is seen in RUNNING.
- running/magnetron_on change one cycle after the causing input. door_open rising drops magnetron_on within 1 cycle (10 ms).
- done asserts in the same cycle the digits show 00:00 and stays high exactly DONE_CYCLES cycles.
- Load to display latency: 1 cycle.

## Structure
- Package microwave_pkg: state enum (IDLE, RUNNING, PAUSED, DONE), BCD constants (DIGIT_MAX = 9, SEC_TENS_MAX = 5), and a bcd_valid check for the time format.
- Sub-module bcd_down_digit: parameter WRAP; inputs dec_en, d; outputs q (d-1, or WRAP when d = 0) and borrow (d == 0 & dec_en). Instantiated four times: WRAP 9/5/9/9.
- Top module contains the FSM, Hz1 edge register, done counter, and output registers.

## Test plan
- Reset, load 01:05, start, 65 Hz1 rising edges -> display counts 01:04, 01:03 … 00:59 … 00:00; done high exactly 100 cycles, then IDLE.
- Borrow chain: load 10:00, start, one tick -> 09:59; load 00:10, one tick -> 00:09.
- Invalid load: 00:30 loaded, then load 00:75 or 0A:00 -> display stays 00:30.
- Door/pause: running at 00:20, door_open = 1 -> magnetron_on 0 next cycle, PAUSED, ticks ignored; start while door open ignored; door closed + start -> resumes from 00:20.
- Simultaneous events: tick with pause -> no decrement; cancel with start -> IDLE, 00:00; start at 00:00 -> stays IDLE.
- Reset mid-run at 00:42 -> all outputs 0, IDLE, display 00:00 next cycle.
